// File: rtl/fifo_wr_scheduler_pkg.sv
// Shared types for the FIFO write scheduler: arbiter state encoding
// and the almost_full threshold test used by the level tracker.
package fifo_wr_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } sched_state_t;

    // True when lvl sits within margin words of a 2**w deep FIFO.
    function automatic logic af_flag(
        input int unsigned lvl,
        input int unsigned w,
        input int unsigned margin
    );
        int unsigned depth;
        depth = 32'd1 << w;
        return lvl >= (depth - margin);
    endfunction

endpackage

// File: rtl/fifo_wr_scheduler_level_counter.sv
// Occupancy tracker for a 2**W deep FIFO: level and registered almost_full.
// Ports: clk, reset (async high), i_wr/i_rd strobes, o_level, o_almost_full.
module fifo_level_counter
    import fifo_wr_scheduler_pkg::*;
#(
    parameter int W         = 10,
    parameter int AF_MARGIN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr,
    input  logic       i_rd,
    output logic [W:0] o_level,
    output logic       o_almost_full
);

    logic [W:0] r_level;
    logic       r_af;
    logic [W:0] w_level_nxt;

    // A read at level 0 has nothing to remove: with a concurrent write
    // the new word lands and the level becomes 1; alone it is ignored.
    always_comb begin
        w_level_nxt = r_level;
        if (i_wr && i_rd) begin
            if (r_level == '0)
                w_level_nxt = (W+1)'(1);
        end else if (i_wr) begin
            w_level_nxt = r_level + (W+1)'(1);
        end else if (i_rd && (r_level != '0)) begin
            w_level_nxt = r_level - (W+1)'(1);
        end
    end

    // almost_full follows the next level so both flags move together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
            r_af    <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_af    <= af_flag(32'(w_level_nxt), W, AF_MARGIN);
        end
    end

    assign o_level       = r_level;
    assign o_almost_full = r_af;

endmodule

// File: rtl/fifo_wr_scheduler.sv
// Round-robin burst scheduler sharing one FIFO write port between two
// producers. Ports: clk, reset, req0/data0, req1/data1, gnt0/gnt1,
// fifo_wr, fifo_w_data, fifo_full, fifo_rd, level, almost_full.
module fifo_wr_scheduler
    import fifo_wr_scheduler_pkg::*;
#(
    parameter int B         = 8,
    parameter int W         = 10,
    parameter int BURST     = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [B-1:0] data0,
    input  logic         req1,
    input  logic [B-1:0] data1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         fifo_wr,
    output logic [B-1:0] fifo_w_data,
    input  logic         fifo_full,
    input  logic         fifo_rd,
    output logic [W:0]   level,
    output logic         almost_full
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    sched_state_t  w_pick;
    logic [BW-1:0] r_beat;
    logic [BW-1:0] w_beat_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_pick      = ST_IDLE;
        w_end       = 1'b1;
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_last_nxt  = r_last;

        w_gnt0 = (r_state == ST_G0) && req0 && !fifo_full;
        w_gnt1 = (r_state == ST_G1) && req1 && !fifo_full;

        // Contention goes to whoever did not own the previous burst.
        if (req0 && req1)
            w_pick = r_last ? ST_G0 : ST_G1;
        else if (req0)
            w_pick = ST_G0;
        else if (req1)
            w_pick = ST_G1;

        // A stalled owner (full, still requesting) keeps the port.
        unique case (r_state)
            ST_G0:   w_end = !req0 || (w_gnt0 && (r_beat == LAST_BEAT));
            ST_G1:   w_end = !req1 || (w_gnt1 && (r_beat == LAST_BEAT));
            default: w_end = 1'b1;
        endcase

        if (w_end) begin
            w_state_nxt = w_pick;
            w_beat_nxt  = '0;
            if (w_pick == ST_G0)
                w_last_nxt = 1'b0;
            else if (w_pick == ST_G1)
                w_last_nxt = 1'b1;
        end else if (w_gnt0 || w_gnt1) begin
            w_beat_nxt = r_beat + BW'(1);
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign fifo_wr = w_gnt0 | w_gnt1;

    always_comb begin
        fifo_w_data = '0;
        if (r_state == ST_G0)
            fifo_w_data = data0;
        else if (r_state == ST_G1)
            fifo_w_data = data1;
    end

    fifo_level_counter #(
        .W         (W),
        .AF_MARGIN (AF_MARGIN)
    ) u_level (
        .clk           (clk),
        .reset         (reset),
        .i_wr          (w_gnt0 | w_gnt1),
        .i_rd          (fifo_rd),
        .o_level       (level),
        .o_almost_full (almost_full)
    );

endmodule

// File: tb/tb_fifo_wr_scheduler.sv
// Scoreboard bench for fifo_wr_scheduler: expected writes are queued by
// the stimulus and popped by a monitor on every fifo_wr.
module tb_fifo_wr_scheduler;

    localparam int B     = 8;
    localparam int W     = 10;
    localparam int BURST = 4;
    localparam int AFM   = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [B-1:0] data0 = '0;
    logic [B-1:0] data1 = '0;
    logic         gnt0;
    logic         gnt1;
    logic         fifo_wr;
    logic [B-1:0] fifo_w_data;
    logic         fifo_full = 1'b0;
    logic         fifo_rd = 1'b0;
    logic [W:0]   level;
    logic         almost_full;

    typedef struct packed {
        logic         port;
        logic [B-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    fifo_wr_scheduler #(
        .B(B), .W(W), .BURST(BURST), .AF_MARGIN(AFM)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0),
        .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .fifo_wr(fifo_wr), .fifo_w_data(fifo_w_data),
        .fifo_full(fifo_full), .fifo_rd(fifo_rd),
        .level(level), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic p, input logic [B-1:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && fifo_wr) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h required=none",
                         fifo_w_data);
            end else begin
                e = sb_q.pop_front();
                check("wr_port", 32'({gnt1, gnt0}),
                      e.port ? 32'd2 : 32'd1);
                check("wr_data", 32'(fifo_w_data), 32'(e.data));
            end
        end
    end

    // Producers hold req/data until their grant is seen, then advance.
    task automatic drive(input int n0, input logic [B-1:0] b0,
                         input int n1, input logic [B-1:0] b1,
                         input bit keep, output int ncyc);
        int   k0;
        int   k1;
        logic g0;
        logic g1;
        k0 = 0;
        k1 = 0;
        ncyc = 0;
        req0 = (n0 > 0);
        data0 = b0;
        req1 = (n1 > 0);
        data1 = b1;
        while ((k0 < n0 || k1 < n1) && ncyc < 2000) begin
            @(negedge clk);
            g0 = gnt0;
            g1 = gnt1;
            @(posedge clk);
            #1;
            ncyc++;
            if (g0) k0++;
            if (g1) k1++;
            req0 = (k0 < n0) || (keep && n0 > 0);
            req1 = (k1 < n1) || (keep && n1 > 0);
            data0 = b0 + 8'(k0);
            data1 = b1 + 8'(k1);
        end
        check("drive_words", 32'(k0 + k1), 32'(n0 + n1));
    endtask

    task automatic wr_rd(input logic [B-1:0] d, input logic rd);
        int n;
        n = 0;
        push(1'b0, d);
        req0 = 1'b1;
        data0 = d;
        @(negedge clk);
        while (!gnt0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("wr_rd_gnt", 32'(gnt0), 32'd1);
        fifo_rd = rd;
        @(posedge clk);
        #1;
        fifo_rd = 1'b0;
        req0 = 1'b0;
    endtask

    task automatic rd_only();
        fifo_rd = 1'b1;
        @(posedge clk);
        #1;
        fifo_rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        fifo_rd = 1'b0;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", 32'({gnt0, gnt1, fifo_wr, fifo_w_data}), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        reset = 1'b0;

        // single producer, 5 words, no gaps after the arbitration cycle
        for (int i = 0; i < 5; i++) push(1'b0, 8'h10 + 8'(i));
        drive(5, 8'h10, 0, 8'h00, 1'b0, cyc);
        check("t1_cycles", 32'(cyc), 32'd6);
        check("t1_level", 32'(level), 32'd5);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // both requesting: bursts of 4, requester 0 first
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) push(1'b0, 8'h20 + 8'(4*b + i));
            for (int i = 0; i < 4; i++) push(1'b1, 8'h40 + 8'(4*b + i));
        end
        drive(8, 8'h20, 8, 8'h40, 1'b0, cyc);
        check("t2_cycles", 32'(cyc), 32'd17);
        check("t2_level", 32'(level), 32'd16);
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // fifo_full stall mid-burst keeps the beat count
        do_reset();
        push(1'b1, 8'hA0);
        push(1'b1, 8'hA1);
        drive(0, 8'h00, 2, 8'hA0, 1'b1, cyc);
        check("t3_first_cycles", 32'(cyc), 32'd3);
        fifo_full = 1'b1;
        req0 = 1'b1;
        data0 = 8'hB0;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall", 32'({gnt0, gnt1, fifo_wr}), 32'd0);
            @(posedge clk);
            #1;
        end
        check("t3_stall_level", 32'(level), 32'd2);
        fifo_full = 1'b0;
        push(1'b1, 8'hA2);
        push(1'b1, 8'hA3);
        push(1'b0, 8'hB0);
        push(1'b0, 8'hB1);
        push(1'b1, 8'hA4);
        push(1'b1, 8'hA5);
        drive(2, 8'hB0, 4, 8'hA2, 1'b0, cyc);
        check("t3_level", 32'(level), 32'd8);
        check("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // simultaneous read/write and read saturation at 0
        do_reset();
        wr_rd(8'h55, 1'b1);
        check("t4_rdwr_at0", 32'(level), 32'd1);
        for (int i = 0; i < 6; i++) push(1'b0, 8'h60 + 8'(i));
        drive(6, 8'h60, 0, 8'h00, 1'b0, cyc);
        check("t4_level7", 32'(level), 32'd7);
        wr_rd(8'h77, 1'b1);
        check("t4_rdwr_at7", 32'(level), 32'd7);
        repeat (7) rd_only();
        check("t4_drained", 32'(level), 32'd0);
        rd_only();
        check("t4_rd_at0", 32'(level), 32'd0);
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // almost_full threshold at 1020, full level 1024
        do_reset();
        for (int i = 0; i < 1019; i++) push(1'b0, 8'(i));
        drive(1019, 8'h00, 0, 8'h00, 1'b0, cyc);
        check("t5_l1019", 32'(level), 32'd1019);
        check("t5_af_1019", 32'(almost_full), 32'd0);
        push(1'b0, 8'hC0);
        drive(1, 8'hC0, 0, 8'h00, 1'b0, cyc);
        check("t5_l1020", 32'(level), 32'd1020);
        check("t5_af_1020", 32'(almost_full), 32'd1);
        rd_only();
        check("t5_rd_l1019", 32'(level), 32'd1019);
        check("t5_rd_af", 32'(almost_full), 32'd0);
        for (int i = 0; i < 5; i++) push(1'b0, 8'hD0 + 8'(i));
        drive(5, 8'hD0, 0, 8'h00, 1'b0, cyc);
        check("t5_l1024", 32'(level), 32'd1024);
        check("t5_af_1024", 32'(almost_full), 32'd1);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // reset mid-burst at beat 2, level 9
        do_reset();
        for (int i = 0; i < 7; i++) push(1'b0, 8'h80 + 8'(i));
        drive(7, 8'h80, 0, 8'h00, 1'b0, cyc);
        @(posedge clk);
        #1;
        push(1'b0, 8'h90);
        push(1'b0, 8'h91);
        drive(2, 8'h90, 0, 8'h00, 1'b1, cyc);
        check("t6_level9", 32'(level), 32'd9);
        req1 = 1'b1;
        data1 = 8'h70;
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_outs", 32'({gnt0, gnt1, fifo_wr, fifo_w_data}), 32'd0);
        check("t6_rst_level", 32'(level), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(1'b0, 8'h60);
        push(1'b0, 8'h61);
        push(1'b1, 8'h70);
        push(1'b1, 8'h71);
        drive(2, 8'h60, 2, 8'h70, 1'b0, cyc);
        check("t6_cycles", 32'(cyc), 32'd6);
        check("t6_level", 32'(level), 32'd4);
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
